// File: rtl/xor_parity_scheduler.sv
// Round-robin scheduler sharing one 1-bit XOR stage between two requesters.
// The granted word is folded serially, one bit per clock, into its parity.
module xor_parity_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             parity,
  output logic             done_id
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             id_q, id_d;
  logic             last_id_q, last_id_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             parity_q, parity_d;
  logic             done_id_q, done_id_d;

  // The shared XOR resource: a ^ b
  logic xor_a, xor_b, xor_y;
  assign xor_a = acc_q;
  assign xor_b = sh_q[0];
  assign xor_y = xor_a ^ xor_b;

  // Requester 1 wins when alone, or on a tie when 0 was served last
  logic any_req, pick1, last_bit;
  assign any_req  = req0 | req1;
  assign pick1    = req1 & (~req0 | ~last_id_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    last_id_d = last_id_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    parity_d  = parity_q;
    done_id_d = done_id_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          sh_d      = pick1 ? data1 : data0;
          acc_d     = 1'b0;
          cnt_d     = '0;
          id_d      = pick1;
          last_id_d = pick1;
          gnt0_d    = ~pick1;
          gnt1_d    = pick1;
          busy_d    = 1'b1;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = xor_y;
        sh_d  = sh_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          parity_d  = xor_y;
          done_id_d = id_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sh_q      <= '0;
      acc_q     <= 1'b0;
      cnt_q     <= '0;
      id_q      <= 1'b0;
      last_id_q <= 1'b1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      parity_q  <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      last_id_q <= last_id_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      parity_q  <= parity_d;
      done_id_q <= done_id_d;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign parity  = parity_q;
  assign done_id = done_id_q;

endmodule
